// File: rtl/sram_bus_responder.sv
`default_nettype none
// ============================================================================
// Module   : sram_bus_responder
// Purpose  : Bridges the cache memory bus to a 16-bit asynchronous SRAM.
//            It performs 4-beat aligned read bursts and single-halfword writes.
// Revision : 1.0 - initial release
// ============================================================================
module sram_bus_responder #(
   parameter int ADDR_W      = 18,
   parameter int WAIT_CYCLES = 1
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              MStrobe,
   input  logic              MRW,
   input  logic [31:0]       MAddress,
   input  logic [15:0]       MDataIn,
   output logic [31:0]       MData,
   output logic              MReady,
   output logic              MDone,
   output logic              Busy,
   output logic [ADDR_W-1:0] SramAddr,
   output logic [15:0]       SramDataOut,
   input  logic [15:0]       SramDataIn,
   output logic              SramDataOE,
   output logic              SramCE_n,
   output logic              SramOE_n,
   output logic              SramWE_n
);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      RD_ACCESS = 3'd1,
      RD_BEAT   = 3'd2,
      WR_SETUP  = 3'd3,
      WR_PULSE  = 3'd4,
      WR_HOLD   = 3'd5,
      DONE      = 3'd6
   } state_t;

   localparam logic [3:0] c_wait = 4'(WAIT_CYCLES);

   state_t            r_state;
   logic [ADDR_W-3:0] r_base;
   logic [1:0]        r_beat;
   logic [3:0]        r_cnt;

   // Address bits above the SRAM range are intentionally ignored.
   logic w_unused_addr;
   assign w_unused_addr = ^MAddress[31:ADDR_W];

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         r_state     <= IDLE;
         r_base      <= '0;
         r_beat      <= 2'd0;
         r_cnt       <= 4'd0;
         MData       <= 32'd0;
         MReady      <= 1'b0;
         MDone       <= 1'b0;
         Busy        <= 1'b0;
         SramAddr    <= '0;
         SramDataOut <= 16'd0;
         SramDataOE  <= 1'b0;
         SramCE_n    <= 1'b1;
         SramOE_n    <= 1'b1;
         SramWE_n    <= 1'b1;
      end else begin
         MReady <= 1'b0;
         MDone  <= 1'b0;
         case (r_state)
            IDLE: begin
               if (MStrobe) begin
                  r_base   <= MAddress[ADDR_W-1:2];
                  r_beat   <= 2'd0;
                  r_cnt    <= c_wait;
                  Busy     <= 1'b1;
                  SramCE_n <= 1'b0;
                  if (MRW) begin
                     SramAddr <= {MAddress[ADDR_W-1:2], 2'b00};
                     SramOE_n <= 1'b0;
                     r_state  <= RD_ACCESS;
                  end else begin
                     SramAddr    <= MAddress[ADDR_W-1:0];
                     SramDataOut <= MDataIn;
                     SramDataOE  <= 1'b1;
                     r_state     <= WR_SETUP;
                  end
               end
            end
            RD_ACCESS: begin
               if (r_cnt == 4'd0) begin
                  MData    <= {SramDataIn, SramDataIn};
                  MReady   <= 1'b1;
                  SramOE_n <= 1'b1;
                  SramCE_n <= 1'b1;
                  r_state  <= RD_BEAT;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            RD_BEAT: begin
               if (r_beat == 2'd3) begin
                  MDone   <= 1'b1;
                  r_state <= DONE;
               end else begin
                  // Beat offset wraps inside the 4-halfword block.
                  r_beat   <= r_beat + 2'd1;
                  SramAddr <= {r_base, r_beat + 2'd1};
                  r_cnt    <= c_wait;
                  SramCE_n <= 1'b0;
                  SramOE_n <= 1'b0;
                  r_state  <= RD_ACCESS;
               end
            end
            WR_SETUP: begin
               SramWE_n <= 1'b0;
               r_cnt    <= c_wait;
               r_state  <= WR_PULSE;
            end
            WR_PULSE: begin
               if (r_cnt == 4'd0) begin
                  SramWE_n <= 1'b1;
                  r_state  <= WR_HOLD;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            WR_HOLD: begin
               SramDataOE <= 1'b0;
               SramCE_n   <= 1'b1;
               MDone      <= 1'b1;
               r_state    <= DONE;
            end
            DONE: begin
               Busy    <= 1'b0;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_sram_bus_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_bus_responder
// Purpose  : Scoreboard bench driving three responders (W = 0, 1, 15) in lockstep.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_bus_responder;
   localparam int AW    = 12;
   localparam int ND    = 3;
   localparam int MEMSZ = 1 << AW;
   localparam int MAXC  = 8192;

   typedef struct {
      int          cyc;
      bit          done;
      logic [31:0] data;
   } exp_t;

   logic          Clk;
   logic          Reset;
   logic          MStrobe;
   logic          MRW;
   logic [31:0]   MAddress;
   logic [15:0]   MDataIn;
   logic [31:0]   MData       [ND];
   logic          MReady      [ND];
   logic          MDone       [ND];
   logic          Busy        [ND];
   logic [AW-1:0] SramAddr    [ND];
   logic [15:0]   SramDataOut [ND];
   logic [15:0]   SramDataIn  [ND];
   logic          SramDataOE  [ND];
   logic          SramCE_n    [ND];
   logic          SramOE_n    [ND];
   logic          SramWE_n    [ND];

   int   cyc = 0;
   int   nchecks = 0;
   int   nerrs = 0;
   int   last_done = 0;
   exp_t sbq [ND][$];
   bit   eb  [ND][MAXC];
   bit   ewe [ND][MAXC];
   bit   eoe [ND][MAXC];
   bit   edo [ND][MAXC];
   logic [15:0] ref_mem [MEMSZ];

   function automatic int wof(input int i);
      return (i == 0) ? 0 : ((i == 1) ? 1 : 15);
   endfunction

   function automatic logic [15:0] init_val(input int a);
      if (a >= 32'h100 && a <= 32'h103) return 16'((a - 32'hFF) * 32'h1111);
      return 16'(a * 40503 + 12345);
   endfunction

   task automatic check(input bit ok, input string nm, input int d,
                        input logic [31:0] act, input logic [31:0] req);
      nchecks++;
      if (!ok) begin
         nerrs++;
         $display("FAIL %s dut%0d cyc %0d actual %h required %h", nm, d, cyc, act, req);
      end
   endtask

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;
   always @(posedge Clk) cyc <= cyc + 1;

   for (genvar g = 0; g < ND; g++) begin : g_dut
      logic [15:0] mem [MEMSZ];
      exp_t        e;

      initial for (int a = 0; a < MEMSZ; a++) mem[a] = init_val(a);

      assign SramDataIn[g] = (!SramCE_n[g] && !SramOE_n[g]) ? mem[SramAddr[g]] : 16'hDEAD;

      always @(posedge Clk)
         if (!SramCE_n[g] && !SramWE_n[g] && SramDataOE[g]) mem[SramAddr[g]] = SramDataOut[g];

      sram_bus_responder #(
         .ADDR_W      (AW),
         .WAIT_CYCLES ((g == 0) ? 0 : ((g == 1) ? 1 : 15))
      ) u_dut (
         .Clk         (Clk),
         .Reset       (Reset),
         .MStrobe     (MStrobe),
         .MRW         (MRW),
         .MAddress    (MAddress),
         .MDataIn     (MDataIn),
         .MData       (MData[g]),
         .MReady      (MReady[g]),
         .MDone       (MDone[g]),
         .Busy        (Busy[g]),
         .SramAddr    (SramAddr[g]),
         .SramDataOut (SramDataOut[g]),
         .SramDataIn  (SramDataIn[g]),
         .SramDataOE  (SramDataOE[g]),
         .SramCE_n    (SramCE_n[g]),
         .SramOE_n    (SramOE_n[g]),
         .SramWE_n    (SramWE_n[g])
      );

      // Response monitor: pops the scoreboard whenever a beat or completion appears.
      always @(negedge Clk) begin
         if (Reset && cyc < MAXC) begin
            while (sbq[g].size() > 0 && sbq[g][0].cyc < cyc) begin
               e = sbq[g].pop_front();
               check(1'b0, "missed_response", g, 32'(cyc), 32'(e.cyc));
            end
            if (MReady[g] || MDone[g]) begin
               if (sbq[g].size() == 0) begin
                  check(1'b0, "unexpected_response", g, {30'd0, MReady[g], MDone[g]}, 32'd0);
               end else begin
                  e = sbq[g].pop_front();
                  check(e.cyc == cyc, "response_cycle", g, 32'(cyc), 32'(e.cyc));
                  check(MDone[g] == e.done && MReady[g] == !e.done, "response_kind", g,
                        {30'd0, MReady[g], MDone[g]}, {30'd0, !e.done, e.done});
                  if (!e.done) check(MData[g] == e.data, "read_data", g, MData[g], e.data);
               end
            end
            check(Busy[g] == eb[g][cyc], "busy", g, 32'(Busy[g]), 32'(eb[g][cyc]));
            check(!SramWE_n[g] == ewe[g][cyc], "we_n_low", g, 32'(!SramWE_n[g]), 32'(ewe[g][cyc]));
            check(!SramOE_n[g] == eoe[g][cyc], "oe_n_low", g, 32'(!SramOE_n[g]), 32'(eoe[g][cyc]));
            check(SramDataOE[g] == edo[g][cyc], "data_oe", g, 32'(SramDataOE[g]), 32'(edo[g][cyc]));
            check(!(!SramOE_n[g] && SramDataOE[g]), "bus_contention", g,
                  {30'd0, !SramOE_n[g], SramDataOE[g]}, 32'd0);
         end
      end
   end

   // Reference model: derives every expected event from the strobe window alone.
   task automatic issue(input bit rw, input int addr, input logic [15:0] wd,
                        input int t0, input int tend);
      exp_t e;
      int   w, t, dn, a;
      last_done = t0;
      if (!rw) ref_mem[addr] = wd;
      for (int i = 0; i < ND; i++) begin
         w = wof(i);
         t = t0;
         while (t <= tend) begin
            if (rw) begin
               for (int k = 0; k < 4; k++) begin
                  a = t + 1 + k * (w + 2);
                  for (int c = a; c <= a + w; c++) eoe[i][c] = 1'b1;
                  e.cyc  = a + w + 1;
                  e.done = 1'b0;
                  e.data = {2{ref_mem[(addr & ~3) | k]}};
                  sbq[i].push_back(e);
               end
               dn = t + 1 + 4 * (w + 2);
            end else begin
               for (int c = t + 2; c <= t + 2 + w; c++) ewe[i][c] = 1'b1;
               for (int c = t + 1; c <= t + 3 + w; c++) edo[i][c] = 1'b1;
               dn = t + 4 + w;
            end
            for (int c = t + 1; c <= dn; c++) eb[i][c] = 1'b1;
            e.cyc  = dn;
            e.done = 1'b1;
            e.data = 32'd0;
            sbq[i].push_back(e);
            if (dn > last_done) last_done = dn;
            t = dn + 1;
         end
      end
   endtask

   task automatic run_txn(input bit rw, input int addr, input logic [15:0] wd, input int hold);
      MStrobe  = 1'b1;
      MRW      = rw;
      MAddress = ($urandom & ~32'(MEMSZ - 1)) | 32'(addr);
      MDataIn  = wd;
      issue(rw, addr, wd, cyc, cyc + hold);
      repeat (hold + 1) @(negedge Clk);
      MStrobe  = 1'b0;
      MRW      = 1'($urandom);
      MAddress = $urandom;
      MDataIn  = 16'($urandom);
      while (cyc <= last_done) @(negedge Clk);
   endtask

   task automatic chk_reset_vals();
      for (int i = 0; i < ND; i++) begin
         check({MReady[i], MDone[i], Busy[i], SramDataOE[i], SramCE_n[i], SramOE_n[i], SramWE_n[i]}
               == 7'b0000111, "reset_ctrl", i,
               {25'd0, MReady[i], MDone[i], Busy[i], SramDataOE[i], SramCE_n[i], SramOE_n[i], SramWE_n[i]},
               32'h7);
         check(MData[i] == 32'd0, "reset_mdata", i, MData[i], 32'd0);
         check(SramAddr[i] == '0 && SramDataOut[i] == 16'd0, "reset_sram_bus", i,
               {4'd0, SramAddr[i], SramDataOut[i]}, 32'd0);
      end
   endtask

   initial begin
      int t0;
      Reset    = 1'b0;
      MStrobe  = 1'b0;
      MRW      = 1'b0;
      MAddress = 32'd0;
      MDataIn  = 16'd0;
      for (int a = 0; a < MEMSZ; a++) ref_mem[a] = init_val(a);
      repeat (3) @(negedge Clk);
      chk_reset_vals();
      #3 Reset = 1'b1;
      @(negedge Clk);

      run_txn(1'b1, 32'h100, 16'h0, 0);
      run_txn(1'b1, 32'h107, 16'h0, 0);
      run_txn(1'b0, 32'h2A5, 16'hBEEF, 0);
      run_txn(1'b1, 32'h2A4, 16'h0, 0);
      run_txn(1'b0, 32'h000, 16'h1234, 0);
      run_txn(1'b1, 32'hFFF, 16'h0, 0);
      // Strobe held until the slowest responder's completion cycle.
      run_txn(1'b1, 32'h3F2, 16'h0, 69);

      // Reset in the middle of a burst: no completion may follow.
      MStrobe  = 1'b1;
      MRW      = 1'b1;
      MAddress = 32'h155;
      t0       = cyc;
      issue(1'b1, 32'h155, 16'h0, t0, t0);
      @(negedge Clk);
      MStrobe = 1'b0;
      while (cyc < t0 + 8) @(negedge Clk);
      #3 Reset = 1'b0;
      #1 chk_reset_vals();
      for (int i = 0; i < ND; i++) begin
         sbq[i].delete();
         for (int c = cyc; c < MAXC; c++) begin
            eb[i][c]  = 1'b0;
            ewe[i][c] = 1'b0;
            eoe[i][c] = 1'b0;
            edo[i][c] = 1'b0;
         end
      end
      repeat (2) @(negedge Clk);
      #3 Reset = 1'b1;
      @(negedge Clk);
      run_txn(1'b1, 32'h101, 16'h0, 0);

      for (int n = 0; n < 40 && cyc < MAXC - 300; n++) begin
         run_txn(1'($urandom_range(0, 1)), int'($urandom_range(0, MEMSZ - 1)), 16'($urandom),
                 ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 20)) : 0);
      end

      repeat (5) @(negedge Clk);
      for (int i = 0; i < ND; i++)
         check(sbq[i].size() == 0, "scoreboard_drained", i, 32'(sbq[i].size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", nchecks, nerrs);
      $finish;
   end

endmodule
`default_nettype wire
